// File: rtl/key_debounce.sv
// Purpose : multi-key push-button conditioner. Each active-low raw key is synchronised,
//           debounced by its own FSM and presented as a clean level plus press/release pulses.
// Latency : KEY_LEVEL and the event pulse appear after edge DEB_CYCLES+1, where edge 0 is the
//           first edge that samples a stable raw change.
// Backpres: none. Pulses last one cycle and are never held off.
//
// Ports:
//   CLK          system clock
//   RST          asynchronous, active-high reset
//   KEY_IN       raw key pins, active-low (0 = pressed), asynchronous to CLK
//   KEY_LEVEL    debounced key state, 1 = pressed
//   KEY_PRESS    one-cycle pulse per key when a press is accepted
//   KEY_RELEASE  one-cycle pulse per key when a release is accepted
//   KEY_ANY      one-cycle pulse when any key press is accepted (same cycle as KEY_PRESS)
module key_debounce #(
    parameter int unsigned KEY_NUM    = 3,
    parameter logic [22:0] DEB_CYCLES = 23'd1_000_000
) (
    input  logic               CLK,
    input  logic               RST,
    input  logic [KEY_NUM-1:0] KEY_IN,
    output logic [KEY_NUM-1:0] KEY_LEVEL,
    output logic [KEY_NUM-1:0] KEY_PRESS,
    output logic [KEY_NUM-1:0] KEY_RELEASE,
    output logic               KEY_ANY
);

    typedef enum logic [1:0] {
        IDLE_UP     = 2'd0,
        FILTER_DOWN = 2'd1,
        HELD_DOWN   = 2'd2,
        FILTER_UP   = 2'd3
    } state_t;

    // The filter counts the sample that started it, so the last accepted sample
    // is the one where cnt already holds DEB_CYCLES-1.
    localparam logic [22:0] CNT_LAST = DEB_CYCLES - 23'd1;

    logic [KEY_NUM-1:0] sync_a;
    logic [KEY_NUM-1:0] sync_s;

    state_t      state     [KEY_NUM];
    state_t      state_nxt [KEY_NUM];
    logic [22:0] cnt       [KEY_NUM];
    logic [22:0] cnt_nxt   [KEY_NUM];

    logic [KEY_NUM-1:0] press_nxt;
    logic [KEY_NUM-1:0] release_nxt;
    logic [KEY_NUM-1:0] level_nxt;

    // Two-stage synchroniser; resets to the released level so a key held
    // through reset is seen as a fresh press afterwards.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            sync_a <= '1;
            sync_s <= '1;
        end else begin
            sync_a <= KEY_IN;
            sync_s <= sync_a;
        end
    end

    always_comb begin
        for (int k = 0; k < KEY_NUM; k++) begin
            state_nxt[k]   = state[k];
            cnt_nxt[k]     = cnt[k];
            press_nxt[k]   = 1'b0;
            release_nxt[k] = 1'b0;
            case (state[k])
                IDLE_UP: begin
                    if (!sync_s[k]) begin
                        state_nxt[k] = FILTER_DOWN;
                        cnt_nxt[k]   = 23'd1;
                    end else begin
                        cnt_nxt[k]   = '0;
                    end
                end
                FILTER_DOWN: begin
                    // A revert on the final sample is checked first, so it wins.
                    if (sync_s[k]) begin
                        state_nxt[k] = IDLE_UP;
                        cnt_nxt[k]   = '0;
                    end else if (cnt[k] == CNT_LAST) begin
                        state_nxt[k] = HELD_DOWN;
                        cnt_nxt[k]   = '0;
                        press_nxt[k] = 1'b1;
                    end else begin
                        cnt_nxt[k]   = cnt[k] + 23'd1;
                    end
                end
                HELD_DOWN: begin
                    if (sync_s[k]) begin
                        state_nxt[k] = FILTER_UP;
                        cnt_nxt[k]   = 23'd1;
                    end else begin
                        cnt_nxt[k]   = '0;
                    end
                end
                FILTER_UP: begin
                    if (!sync_s[k]) begin
                        state_nxt[k]   = HELD_DOWN;
                        cnt_nxt[k]     = '0;
                    end else if (cnt[k] == CNT_LAST) begin
                        state_nxt[k]   = IDLE_UP;
                        cnt_nxt[k]     = '0;
                        release_nxt[k] = 1'b1;
                    end else begin
                        cnt_nxt[k]     = cnt[k] + 23'd1;
                    end
                end
                default: begin
                    state_nxt[k] = IDLE_UP;
                    cnt_nxt[k]   = '0;
                end
            endcase
            // Level is "pressed" throughout HELD_DOWN and while a release is still being filtered.
            level_nxt[k] = (state_nxt[k] == HELD_DOWN) || (state_nxt[k] == FILTER_UP);
        end
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            for (int k = 0; k < KEY_NUM; k++) begin
                state[k] <= IDLE_UP;
                cnt[k]   <= '0;
            end
            KEY_LEVEL   <= '0;
            KEY_PRESS   <= '0;
            KEY_RELEASE <= '0;
            KEY_ANY     <= 1'b0;
        end else begin
            for (int k = 0; k < KEY_NUM; k++) begin
                state[k] <= state_nxt[k];
                cnt[k]   <= cnt_nxt[k];
            end
            KEY_LEVEL   <= level_nxt;
            KEY_PRESS   <= press_nxt;
            KEY_RELEASE <= release_nxt;
            KEY_ANY     <= |press_nxt;
        end
    end

endmodule

// File: tb/tb_key_debounce.sv
// Purpose : directed bench for key_debounce with KEY_NUM=3, DEB_CYCLES=8; expected events and
//           quiet-level probes are queued by the stimulus and checked by a separate monitor.
// Latency : events expected 10 cycle-counts after the negedge that drives a change.
// Backpres: none.
module tb_key_debounce;

    localparam int          KN  = 3;
    localparam logic [22:0] DEB = 23'd8;

    logic          CLK = 1'b0;
    logic          RST = 1'b1;
    logic [KN-1:0] KEY_IN = '1;
    logic [KN-1:0] KEY_LEVEL;
    logic [KN-1:0] KEY_PRESS;
    logic [KN-1:0] KEY_RELEASE;
    logic          KEY_ANY;

    key_debounce #(
        .KEY_NUM    (KN),
        .DEB_CYCLES (DEB)
    ) dut (
        .CLK         (CLK),
        .RST         (RST),
        .KEY_IN      (KEY_IN),
        .KEY_LEVEL   (KEY_LEVEL),
        .KEY_PRESS   (KEY_PRESS),
        .KEY_RELEASE (KEY_RELEASE),
        .KEY_ANY     (KEY_ANY)
    );

    always #5 CLK = ~CLK;

    // Number of rising edges seen so far.
    int cyc = 0;
    always @(posedge CLK) cyc <= cyc + 1;

    typedef struct {
        int            at;
        logic [KN-1:0] press;
        logic [KN-1:0] rel;
        logic [KN-1:0] level;
        logic          any;
    } ev_t;

    typedef struct {
        int            at;
        logic [KN-1:0] level;
        string         name;
    } lv_t;

    ev_t ev_q[$];
    lv_t lv_q[$];

    int n_cmp = 0;
    int n_bad = 0;
    bit done  = 1'b0;

    // Called at a negedge right after driving KEY_IN / releasing RST: next posedge is edge 0,
    // the pulse is visible after edge 9, i.e. at the negedge where cyc == now + 10.
    task automatic expect_ev(input logic [KN-1:0] p, input logic [KN-1:0] r,
                             input logic [KN-1:0] l, input logic a);
        ev_t e;
        e.at = cyc + 10; e.press = p; e.rel = r; e.level = l; e.any = a;
        ev_q.push_back(e);
    endtask

    // Quiet probe at the next negedge: level as given, no pulses.
    task automatic probe_next(input logic [KN-1:0] l, input string name);
        lv_t v;
        v.at = cyc + 1; v.level = l; v.name = name;
        lv_q.push_back(v);
    endtask

    // Quiet probe at the coming negedge (used between a posedge and its negedge).
    task automatic probe_now(input logic [KN-1:0] l, input string name);
        lv_t v;
        v.at = cyc; v.level = l; v.name = name;
        lv_q.push_back(v);
    endtask

    task automatic wait_n(input int n);
        repeat (n) @(negedge CLK);
    endtask

    task automatic summary();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    endtask

    // Monitor / scoreboard
    always @(negedge CLK) begin : mon
        ev_t e;
        lv_t v;
        if ((KEY_PRESS | KEY_RELEASE) !== '0 || KEY_ANY !== 1'b0) begin
            n_cmp++;
            if (ev_q.size() == 0) begin
                n_bad++;
                $display("FAIL event_unexpected: cyc=%0d press=%b release=%b level=%b any=%b, required no event",
                         cyc, KEY_PRESS, KEY_RELEASE, KEY_LEVEL, KEY_ANY);
            end else begin
                e = ev_q.pop_front();
                if (e.at != cyc || KEY_PRESS !== e.press || KEY_RELEASE !== e.rel ||
                    KEY_LEVEL !== e.level || KEY_ANY !== e.any) begin
                    n_bad++;
                    $display("FAIL event: got cyc=%0d press=%b release=%b level=%b any=%b, required cyc=%0d press=%b release=%b level=%b any=%b",
                             cyc, KEY_PRESS, KEY_RELEASE, KEY_LEVEL, KEY_ANY,
                             e.at, e.press, e.rel, e.level, e.any);
                end
            end
        end
        if (ev_q.size() > 0 && ev_q[0].at < cyc) begin
            e = ev_q.pop_front();
            n_cmp++;
            n_bad++;
            $display("FAIL event_missing: got nothing by cyc=%0d, required press=%b release=%b at cyc=%0d",
                     cyc, e.press, e.rel, e.at);
        end
        while (lv_q.size() > 0 && lv_q[0].at <= cyc) begin
            v = lv_q.pop_front();
            n_cmp++;
            if (v.at != cyc || KEY_LEVEL !== v.level || KEY_PRESS !== '0 ||
                KEY_RELEASE !== '0 || KEY_ANY !== 1'b0) begin
                n_bad++;
                $display("FAIL %s: got cyc=%0d level=%b press=%b release=%b any=%b, required cyc=%0d level=%b and no pulses",
                         v.name, cyc, KEY_LEVEL, KEY_PRESS, KEY_RELEASE, KEY_ANY, v.at, v.level);
            end
        end
        if (done) begin
            n_cmp++;
            if (ev_q.size() != 0) begin
                n_bad++;
                $display("FAIL events_left: got %0d pending events, required 0", ev_q.size());
            end
            n_cmp++;
            if (lv_q.size() != 0) begin
                n_bad++;
                $display("FAIL probes_left: got %0d pending probes, required 0", lv_q.size());
            end
            summary();
            $finish;
        end else if (cyc > 4000) begin
            n_cmp++;
            n_bad++;
            $display("FAIL timeout: got cyc=%0d without completion, required completion by 4000", cyc);
            summary();
            $finish;
        end
    end

    // Stimulus
    initial begin
        RST    = 1'b1;
        KEY_IN = '1;
        wait_n(2);
        probe_next(3'b000, "reset_state");
        wait_n(2);
        RST = 1'b0;
        wait_n(3);

        // Clean press / release on key 0
        KEY_IN = 3'b110; expect_ev(3'b001, 3'b000, 3'b001, 1'b1);
        wait_n(15);
        probe_next(3'b001, "key0_held");
        wait_n(1);
        KEY_IN = 3'b111; expect_ev(3'b000, 3'b001, 3'b000, 1'b0);
        wait_n(15);

        // Bounce on key 1: low 5, high 2, low 7, high 1, then steady low
        KEY_IN = 3'b101; wait_n(5);
        KEY_IN = 3'b111; wait_n(2);
        KEY_IN = 3'b101; wait_n(7);
        KEY_IN = 3'b111; wait_n(1);
        KEY_IN = 3'b101; expect_ev(3'b010, 3'b000, 3'b010, 1'b1);
        wait_n(15);
        KEY_IN = 3'b111; expect_ev(3'b000, 3'b010, 3'b000, 1'b0);
        wait_n(15);

        // Key 2: 7-cycle low glitch while released, then 7-cycle high glitch while held
        KEY_IN = 3'b011; wait_n(7);
        KEY_IN = 3'b111; wait_n(15);
        probe_next(3'b000, "key2_low_glitch");
        wait_n(1);
        KEY_IN = 3'b011; expect_ev(3'b100, 3'b000, 3'b100, 1'b1);
        wait_n(15);
        KEY_IN = 3'b111; wait_n(7);
        KEY_IN = 3'b011; wait_n(15);
        probe_next(3'b100, "key2_high_glitch");
        wait_n(1);
        KEY_IN = 3'b111; expect_ev(3'b000, 3'b100, 3'b000, 1'b0);
        wait_n(15);

        // Simultaneous press and release of all keys
        KEY_IN = 3'b000; expect_ev(3'b111, 3'b000, 3'b111, 1'b1);
        wait_n(15);
        probe_next(3'b111, "all_held");
        wait_n(1);
        KEY_IN = 3'b111; expect_ev(3'b000, 3'b111, 3'b000, 1'b0);
        wait_n(15);

        // Reset mid-filter, then fresh press after reset with key still low
        KEY_IN = 3'b110;
        wait_n(6);
        @(posedge CLK); #2;
        RST = 1'b1;
        probe_now(3'b000, "reset_mid_filter");
        wait_n(3);
        RST = 1'b0; expect_ev(3'b001, 3'b000, 3'b001, 1'b1);
        wait_n(15);
        probe_next(3'b001, "held_after_reset");
        wait_n(1);
        // Reset while held: level drops at once, no release pulse
        @(posedge CLK); #2;
        RST = 1'b1;
        probe_now(3'b000, "reset_while_held");
        wait_n(1);
        KEY_IN = 3'b111;
        wait_n(2);
        RST = 1'b0;
        wait_n(15);
        probe_next(3'b000, "quiet_after_reset");
        wait_n(1);

        // Final-sample revert on key 0, then a normal press/release
        KEY_IN = 3'b110; wait_n(7);
        KEY_IN = 3'b111; wait_n(15);
        probe_next(3'b000, "final_sample_revert");
        wait_n(1);
        KEY_IN = 3'b110; expect_ev(3'b001, 3'b000, 3'b001, 1'b1);
        wait_n(15);
        KEY_IN = 3'b111; expect_ev(3'b000, 3'b001, 3'b000, 1'b0);
        wait_n(15);

        done = 1'b1;
    end

endmodule

// File: doc/key_debounce.md
# key_debounce

Multi-key input conditioner for the board push-buttons, the input-side counterpart of the LED drivers in the `Flash_Run` family. Each raw active-low key is synchronised, debounced by a per-key state machine, and presented as a clean pressed level plus one-cycle press/release event pulses. LED sequencers and mode logic consume these pulses, for example to start, stop or reverse a running light.

## Interface
- `KEY_NUM`, default 3: number of independent keys.
- `DEB_CYCLES`, default 23'd1_000_000: consecutive stable samples required to accept a change. The default is 20 ms at 50 MHz. Legal range is 2 to 2^23-1.
- `CLK`, input, 1: system clock, 50 MHz nominal.
- `RST`, input, 1: asynchronous, active-high reset.
- `KEY_IN`, input, `KEY_NUM`: raw key pins. Active-low, so 0 means pressed. Asynchronous to `CLK`.
- `KEY_LEVEL`, output, `KEY_NUM`: debounced state. 1 means pressed.
- `KEY_PRESS`, output, `KEY_NUM`: one-cycle pulse when a press is accepted.
- `KEY_RELEASE`, output, `KEY_NUM`: one-cycle pulse when a release is accepted.
- `KEY_ANY`, output, 1: OR of `KEY_PRESS` bits. Wake/activity strobe.

## Operation
- Every key is fully independent. There is no shared counter and no priority between keys.
- **Synchroniser:** two flip-flops per key, with no logic between them. The second stage `s` is the only value the state machine sees.
- **Counter:** 23-bit `cnt` per key. It counts consecutive samples of `s` that agree with the candidate new level, including the sample that started the filter.
- **State machine, per key:**
  - IDLE_UP (released):
    - `s`=0 → FILTER_DOWN, `cnt`←1.
    - Otherwise hold, `cnt`←0.
  - FILTER_DOWN:
    - `s`=1 → IDLE_UP, `cnt`←0. This is a bounce; no event is generated.
    - `s`=0 and `cnt`==`DEB_CYCLES`-1 → HELD_DOWN, `cnt`←0, `KEY_LEVEL`←1, `KEY_PRESS`←1.
    - Otherwise `cnt`←`cnt`+1.
  - HELD_DOWN (pressed):
    - `s`=1 → FILTER_UP, `cnt`←1.
    - Otherwise hold.
  - FILTER_UP:
    - `s`=0 → HELD_DOWN, `cnt`←0. No event is generated.
    - `s`=1 and `cnt`==`DEB_CYCLES`-1 → IDLE_UP, `cnt`←0, `KEY_LEVEL`←0, `KEY_RELEASE`←1.
    - Otherwise `cnt`←`cnt`+1.
- **Outputs:** all outputs are registered. `KEY_PRESS` and `KEY_RELEASE` are high for exactly one cycle and default to 0 on every other cycle. `KEY_ANY` is a registered OR, aligned in the same cycle as `KEY_PRESS`.
- **Arithmetic:** `cnt` never exceeds `DEB_CYCLES`-1, so it cannot wrap.
- **Glitch rejection:** a glitch shorter than `DEB_CYCLES` samples leaves `KEY_LEVEL` unchanged and produces no pulse.

## Timing
- **Reset values:**
  - State IDLE_UP, all `cnt`=0.
  - Synchroniser flip-flops = 1 (the released level).
  - `KEY_LEVEL`=0, `KEY_PRESS`=0, `KEY_RELEASE`=0, `KEY_ANY`=0.
- **Reset mid-operation:** asserting `RST` in any state, including mid-filter or HELD_DOWN, forces the reset values immediately. No release pulse is emitted.
- **After reset release with the key held low:** the block treats this as a fresh press. `KEY_PRESS` fires after the normal latency.
- **Latency:** the first `CLK` edge that samples a stable raw change is edge 0. `KEY_LEVEL` and the event pulse become visible after edge `DEB_CYCLES`+1. That is 2 synchroniser stages plus `DEB_CYCLES` samples, minus the overlap of the first sample.
- **Bounce at the final sample:** if `s` reverts on the same edge where `cnt`==`DEB_CYCLES`-1, the revert wins. The key returns to IDLE_UP or HELD_DOWN and no event is generated.
- **Simultaneous events:** several keys may pulse in the same cycle. `KEY_ANY` is then a single one-cycle pulse.
- **Minimum event spacing per key:** 2×`DEB_CYCLES` cycles between a press and the following press.

## Test plan
All scenarios use `KEY_NUM`=3 and `DEB_CYCLES`=8.
- **Clean press:** hold `KEY_IN[0]` low from edge 0 → `KEY_PRESS[0]`=1 for one cycle after edge 9, with `KEY_LEVEL[0]` rising in the same cycle. Raise it again → `KEY_RELEASE[0]` after 9 further edges and `KEY_LEVEL[0]` falls.
- **Bounce:** toggle `KEY_IN[1]` low 5 cycles, high 2, low 7, high 1, then low steady → exactly one `KEY_PRESS[1]`, 9 edges after the start of the final steady-low run. No other pulses.
- **Released-state glitch:** a 7-cycle low glitch on `KEY_IN[2]` while released → no pulse and `KEY_LEVEL[2]` stays 0. Repeat the glitch as a 7-cycle high glitch while held → no release.
- **Simultaneous press:** drive all three keys low on the same edge → `KEY_PRESS`=3'b111 and `KEY_ANY`=1, both for exactly one cycle.
- **Reset mid-filter and while held:**
  - Assert `RST` 4 cycles into FILTER_DOWN → all outputs 0 immediately.
  - Assert `RST` while a key is held → `KEY_LEVEL` drops to 0 with no `KEY_RELEASE`.
  - Release `RST` with the key still low → `KEY_PRESS` after 9 edges.
- **Final-sample revert:** raise the key so that `s` returns to 1 on the sample where `cnt`==7 → no press, state returns to IDLE_UP, and a subsequent 8-sample low run produces a normal press.
